watch_bcd_conv: RTL

WATCH_BCD_CONV -- requirements
Module: watch_bcd_conv

---
 rtl/watch_bcd_conv.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/watch_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module   : watch_bcd_conv
//  Purpose  : Converts a coherent snapshot of a watch's sec/min/hour/day/year
//             counters to packed BCD. One shared shift-add-3 engine converts
//             the five fields one after another. All outputs update together
//             on a single-cycle done strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module watch_bcd_conv #(
   parameter int P_SEC_BIT  = 6,
   parameter int P_MIN_BIT  = 6,
   parameter int P_HOUR_BIT = 5,
   parameter int P_DAY_BIT  = 9,
   parameter int P_YEAR_BIT = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_run_en,
   input  logic                  i_start,
   input  logic [P_SEC_BIT-1:0]  i_sec,
   input  logic [P_MIN_BIT-1:0]  i_min,
   input  logic [P_HOUR_BIT-1:0] i_hour,
   input  logic [P_DAY_BIT-1:0]  i_day,
   input  logic [P_YEAR_BIT-1:0] i_year,
   output logic [7:0]            o_sec_bcd,
   output logic [7:0]            o_min_bcd,
   output logic [7:0]            o_hour_bcd,
   output logic [11:0]           o_day_bcd,
   output logic [15:0]           o_year_bcd,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int C_BIN_W = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state_q;
   logic [2:0]              field_q;
   logic [3:0]              cnt_q;
   logic [C_BIN_W-1:0]      bin_q;
   logic [15:0]             acc_q;

   // Snapshot of the inputs taken on the accepted start edge
   logic [P_SEC_BIT-1:0]    snap_sec_q;
   logic [P_MIN_BIT-1:0]    snap_min_q;
   logic [P_HOUR_BIT-1:0]   snap_hour_q;
   logic [P_DAY_BIT-1:0]    snap_day_q;
   logic [P_YEAR_BIT-1:0]   snap_year_q;

   // Per-field results waiting for the common output update
   logic [7:0]              hold_sec_q;
   logic [7:0]              hold_min_q;
   logic [7:0]              hold_hour_q;
   logic [11:0]             hold_day_q;
   logic [15:0]             hold_year_q;

   logic [7:0]              sec_bcd_q;
   logic [7:0]              min_bcd_q;
   logic [7:0]              hour_bcd_q;
   logic [11:0]             day_bcd_q;
   logic [15:0]             year_bcd_q;
   logic                    busy_q;
   logic                    done_q;

   logic [C_BIN_W-1:0]      field_bin_d;
   logic [15:0]             acc_adj_d;
   logic [15:0]             acc_d;
   logic [C_BIN_W-1:0]      bin_d;

   // Select the snapshot field currently being converted, zero-extended
   always_comb begin
      field_bin_d = '0;
      case (field_q)
         3'd0:    field_bin_d = C_BIN_W'(snap_sec_q);
         3'd1:    field_bin_d = C_BIN_W'(snap_min_q);
         3'd2:    field_bin_d = C_BIN_W'(snap_hour_q);
         3'd3:    field_bin_d = C_BIN_W'(snap_day_q);
         default: field_bin_d = C_BIN_W'(snap_year_q);
      endcase
   end

   // One double-dabble step: add 3 to nibbles >= 5, then shift {acc,bin} left
   always_comb begin
      acc_adj_d = acc_q;
      for (int n = 0; n < 4; n++) begin
         if (acc_q[4*n +: 4] >= 4'd5) begin
            acc_adj_d[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
         end
      end
      acc_d = {acc_adj_d[14:0], bin_q[C_BIN_W-1]};
      bin_d = {bin_q[C_BIN_W-2:0], 1'b0};
   end

   // Sequencer, engine, snapshot, holding and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         field_q     <= '0;
         cnt_q       <= '0;
         bin_q       <= '0;
         acc_q       <= '0;
         snap_sec_q  <= '0;
         snap_min_q  <= '0;
         snap_hour_q <= '0;
         snap_day_q  <= '0;
         snap_year_q <= '0;
         hold_sec_q  <= '0;
         hold_min_q  <= '0;
         hold_hour_q <= '0;
         hold_day_q  <= '0;
         hold_year_q <= '0;
         sec_bcd_q   <= '0;
         min_bcd_q   <= '0;
         hour_bcd_q  <= '0;
         day_bcd_q   <= '0;
         year_bcd_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            // Accept a request only while enabled; capture a coherent time
            if (i_start && i_run_en) begin
               snap_sec_q  <= i_sec;
               snap_min_q  <= i_min;
               snap_hour_q <= i_hour;
               snap_day_q  <= i_day;
               snap_year_q <= i_year;
               field_q     <= 3'd0;
               busy_q      <= 1'b1;
               state_q     <= LOAD;
            end
         end else if (!i_run_en) begin
            // Abort: drop partial results, leave the outputs untouched
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            field_q     <= '0;
            cnt_q       <= '0;
            bin_q       <= '0;
            acc_q       <= '0;
            hold_sec_q  <= '0;
            hold_min_q  <= '0;
            hold_hour_q <= '0;
            hold_day_q  <= '0;
            hold_year_q <= '0;
         end else begin
            case (state_q)
               LOAD: begin
                  bin_q   <= field_bin_d;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
               SHIFT: begin
                  acc_q <= acc_d;
                  bin_q <= bin_d;
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd11) begin
                     case (field_q)
                        3'd0:    hold_sec_q  <= acc_d[7:0];
                        3'd1:    hold_min_q  <= acc_d[7:0];
                        3'd2:    hold_hour_q <= acc_d[7:0];
                        3'd3:    hold_day_q  <= acc_d[11:0];
                        default: hold_year_q <= acc_d;
                     endcase
                     if (field_q == 3'd4) begin
                        // Year result bypasses its holding register here
                        sec_bcd_q  <= hold_sec_q;
                        min_bcd_q  <= hold_min_q;
                        hour_bcd_q <= hold_hour_q;
                        day_bcd_q  <= hold_day_q;
                        year_bcd_q <= acc_d;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                     end else begin
                        field_q <= field_q + 3'd1;
                        state_q <= LOAD;
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_sec_bcd  = sec_bcd_q;
   assign o_min_bcd  = min_bcd_q;
   assign o_hour_bcd = hour_bcd_q;
   assign o_day_bcd  = day_bcd_q;
   assign o_year_bcd = year_bcd_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;

endmodule
`default_nettype wire
